// File: rtl/pc_update_sequencer.sv
// Multi-cycle control FSM for the program-counter write path.
// It steps through IDLE, FETCH, DECODE, EXEC, UPDATE and HALT, and drives
// the PC-source selects, the PC and IR write strobes and a retired-instruction
// counter.
module pc_update_sequencer #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [2:0]       op_class,
  input  logic             zero_flag,
  input  logic             stall,
  output logic             fetch_req,
  output logic             IR_write,
  output logic             PC_write,
  output logic [1:0]       M1,
  output logic             M7,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StUpdate = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [2:0] OpSeq  = 3'd0;
  localparam logic [2:0] OpJump = 3'd1;
  localparam logic [2:0] OpJr   = 3'd2;
  localparam logic [2:0] OpBeq  = 3'd3;
  localparam logic [2:0] OpBne  = 3'd4;
  localparam logic [2:0] OpHalt = 3'd5;

  localparam int unsigned WaitW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  // Timeout fires on the cycle that would make the wait count reach FETCH_TIMEOUT.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(FETCH_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       m1_q, m1_d;
  logic             m7_q, m7_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state logic; the wait counter clears in every state but FETCH, so
  // it starts at zero on each FETCH entry.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    op_d    = op_q;
    m1_d    = m1_q;
    m7_d    = m7_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        // A valid instruction wins over a coincident timeout.
        if (instr_valid) begin
          state_d = StDecode;
        end else if (wait_q == WaitLast) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        if (!stall) begin
          op_d    = op_class;
          state_d = StExec;
        end
      end
      StExec: begin
        if (!stall) begin
          if (op_q == OpHalt) begin
            state_d = StHalt;
          end else begin
            case (op_q)
              OpJump: m1_d = 2'd0;
              OpJr:   m1_d = 2'd2;
              OpBeq: begin
                m1_d = 2'd1;
                m7_d = zero_flag;
              end
              OpBne: begin
                m1_d = 2'd1;
                m7_d = ~zero_flag;
              end
              default: begin  // seq, and classes 6-7
                m1_d = 2'd1;
                m7_d = 1'b0;
              end
            endcase
            state_d = StUpdate;
          end
        end
      end
      StUpdate: begin
        if (!stall) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      op_q    <= OpSeq;
      m1_q    <= 2'd1;
      m7_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      m1_q    <= m1_d;
      m7_q    <= m7_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are decoded from the current state; selects come straight from flops.
  always_comb begin
    fetch_req   = (state_q == StFetch);
    IR_write    = (state_q == StFetch) && instr_valid;
    PC_write    = (state_q == StUpdate) && !stall;
    halted      = (state_q == StHalt);
    M1          = m1_q;
    M7          = m7_q;
    fetch_err   = err_q;
    instr_count = cnt_q;
  end

endmodule

// File: tb/tb_pc_update_sequencer.sv
// Directed bench for pc_update_sequencer; each scenario task checks inline.
module tb_pc_update_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [2:0]  op_class;
  logic        zero_flag;
  logic        stall;
  logic        fetch_req;
  logic        IR_write;
  logic        PC_write;
  logic [1:0]  M1;
  logic        M7;
  logic        halted;
  logic        fetch_err;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  pc_update_sequencer #(
    .CNT_W        (16),
    .FETCH_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .op_class   (op_class),
    .zero_flag  (zero_flag),
    .stall      (stall),
    .fetch_req  (fetch_req),
    .IR_write   (IR_write),
    .PC_write   (PC_write),
    .M1         (M1),
    .M7         (M7),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reset for two cycles, then check the reset values and the IDLE state.
  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b1; op_class = 3'd0; zero_flag = 1'b0; stall = 1'b0;
    tick(); tick();
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rst_fetch_req got %b exp 0", fetch_req); end
    checks++; if (IR_write !== 1'b0) begin errors++; $display("FAIL rst_ir_write got %b exp 0", IR_write); end
    checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write got %b exp 0", PC_write); end
    checks++; if (M1 !== 2'd1 || M7 !== 1'b0) begin errors++; $display("FAIL rst_sel got M1=%0d M7=%b exp 1/0", M1, M7); end
    checks++; if (halted !== 1'b0 || fetch_err !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", halted, fetch_err); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", instr_count); end
    rst = 1'b0;
    tick();  // IDLE -> FETCH
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL idle_to_fetch got %b exp 1", fetch_req); end
  endtask

  // Run one instruction starting in FETCH with instr_valid=1; ends in the next FETCH.
  // op_class is driven with 'halt' outside DECODE to show it is ignored there.
  task automatic do_instr(input logic [2:0] op, input logic zf, input logic [1:0] em1,
                          input logic em7, input logic [15:0] ecount);
    op_class = 3'd5;
    checks++; if (IR_write !== 1'b1) begin errors++; $display("FAIL fetch_ir_write op%0d got %b exp 1", op, IR_write); end
    tick();  // DECODE
    op_class = op;
    checks++; if (IR_write !== 1'b0 || PC_write !== 1'b0) begin errors++; $display("FAIL decode_strobes op%0d got %b%b exp 00", op, IR_write, PC_write); end
    tick();  // EXEC
    op_class = 3'd5; zero_flag = zf;
    checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL exec_pc_write op%0d got %b exp 0", op, PC_write); end
    tick();  // UPDATE
    zero_flag = ~zf;
    checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL update_pc_write op%0d got %b exp 1", op, PC_write); end
    checks++; if (M1 !== em1) begin errors++; $display("FAIL update_m1 op%0d got %0d exp %0d", op, M1, em1); end
    if (em1 == 2'd1) begin
      checks++; if (M7 !== em7) begin errors++; $display("FAIL update_m7 op%0d zf%b got %b exp %b", op, zf, M7, em7); end
    end
    tick();  // FETCH
    checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL pc_write_single op%0d got %b exp 0", op, PC_write); end
    checks++; if (instr_count !== ecount) begin errors++; $display("FAIL count op%0d got %0d exp %0d", op, instr_count, ecount); end
  endtask

  task automatic test_sequential();
    do_instr(3'd0, 1'b0, 2'd1, 1'b0, 16'd1);
    do_instr(3'd0, 1'b1, 2'd1, 1'b0, 16'd2);
    do_instr(3'd7, 1'b1, 2'd1, 1'b0, 16'd3);
  endtask

  task automatic test_jumps();
    do_instr(3'd1, 1'b0, 2'd0, 1'b0, 16'd4);
    do_instr(3'd2, 1'b0, 2'd2, 1'b0, 16'd5);
  endtask

  task automatic test_branches();
    do_instr(3'd3, 1'b1, 2'd1, 1'b1, 16'd6);
    do_instr(3'd3, 1'b0, 2'd1, 1'b0, 16'd7);
    do_instr(3'd4, 1'b0, 2'd1, 1'b1, 16'd8);
    do_instr(3'd4, 1'b1, 2'd1, 1'b0, 16'd9);
  endtask

  // Stall for 3 cycles on UPDATE entry after a jr.
  task automatic test_stall();
    op_class = 3'd2;
    tick();  // DECODE
    tick();  // EXEC
    tick();  // UPDATE
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL stall_pc_write cycle%0d got %b exp 0", i, PC_write); end
      checks++; if (M1 !== 2'd2) begin errors++; $display("FAIL stall_m1_hold cycle%0d got %0d exp 2", i, M1); end
      if (i < 2) tick();
    end
    checks++; if (instr_count !== 16'd9) begin errors++; $display("FAIL stall_count got %0d exp 9", instr_count); end
    stall = 1'b0;
    #1;
    checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL stall_release_pc_write got %b exp 1", PC_write); end
    tick();  // FETCH
    checks++; if (PC_write !== 1'b0 || fetch_req !== 1'b1) begin errors++; $display("FAIL stall_after got pcw=%b freq=%b exp 0/1", PC_write, fetch_req); end
    checks++; if (instr_count !== 16'd10) begin errors++; $display("FAIL stall_count_once got %0d exp 10", instr_count); end
  endtask

  // Halt class: no PC write, count unchanged, selects held, then reset clears.
  task automatic test_halt_op();
    tick();  // DECODE
    op_class = 3'd5;
    tick();  // EXEC
    op_class = 3'd0;
    checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL halt_exec_pc_write got %b exp 0", PC_write); end
    tick(); tick(); tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_op_halted got %b exp 1", halted); end
    checks++; if (PC_write !== 1'b0 || fetch_req !== 1'b0 || IR_write !== 1'b0) begin errors++; $display("FAIL halt_enables got %b%b%b exp 000", PC_write, fetch_req, IR_write); end
    checks++; if (instr_count !== 16'd10) begin errors++; $display("FAIL halt_count got %0d exp 10", instr_count); end
    checks++; if (M1 !== 2'd2 || fetch_err !== 1'b0) begin errors++; $display("FAIL halt_hold got M1=%0d err=%b exp 2/0", M1, fetch_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (halted !== 1'b0 || instr_count !== 16'd0 || M1 !== 2'd1) begin errors++; $display("FAIL halt_rst got h=%b cnt=%0d M1=%0d exp 0/0/1", halted, instr_count, M1); end
  endtask

  // Instruction memory never responds: timeout after exactly 15 wait cycles.
  task automatic test_timeout();
    instr_valid = 1'b0;
    tick();  // FETCH, wait cycle 1
    for (int i = 0; i < 14; i++) tick();  // wait cycle 15
    checks++; if (fetch_err !== 1'b0 || halted !== 1'b0 || fetch_req !== 1'b1) begin errors++; $display("FAIL timeout_early got err=%b h=%b freq=%b exp 0/0/1", fetch_err, halted, fetch_req); end
    tick();
    checks++; if (fetch_err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL timeout got err=%b h=%b exp 1/1", fetch_err, halted); end
    tick(); tick();
    checks++; if (fetch_err !== 1'b1 || fetch_req !== 1'b0) begin errors++; $display("FAIL timeout_sticky got err=%b freq=%b exp 1/0", fetch_err, fetch_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (fetch_err !== 1'b0 || halted !== 1'b0 || instr_count !== 16'd0) begin errors++; $display("FAIL timeout_rst got err=%b h=%b cnt=%0d exp 0/0/0", fetch_err, halted, instr_count); end
  endtask

  // instr_valid arrives on the timeout cycle and wins; next FETCH starts a fresh wait.
  task automatic test_valid_at_timeout();
    tick();  // FETCH
    for (int i = 0; i < 14; i++) tick();  // wait cycle 15
    instr_valid = 1'b1;
    #1;
    checks++; if (IR_write !== 1'b1) begin errors++; $display("FAIL boundary_ir_write got %b exp 1", IR_write); end
    tick();  // DECODE
    op_class = 3'd0;
    instr_valid = 1'b0;
    checks++; if (fetch_err !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL boundary_no_err got err=%b h=%b exp 0/0", fetch_err, halted); end
    tick(); tick(); tick();  // EXEC, UPDATE, FETCH
    for (int i = 0; i < 14; i++) tick();  // wait cycle 15 of the new FETCH
    checks++; if (fetch_err !== 1'b0 || fetch_req !== 1'b1) begin errors++; $display("FAIL wait_cleared got err=%b freq=%b exp 0/1", fetch_err, fetch_req); end
    instr_valid = 1'b1;
    tick();  // DECODE
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL boundary_count got %0d exp 1", instr_count); end
  endtask

  // Reset during EXEC of a jump: no PC write, back to IDLE with a zero count.
  task automatic test_reset_in_exec();
    op_class = 3'd1;
    tick(); tick(); tick();  // EXEC, UPDATE, FETCH: retire the pending instruction
    checks++; if (instr_count !== 16'd2) begin errors++; $display("FAIL pre_rst_count got %0d exp 2", instr_count); end
    tick();  // DECODE of the jump
    tick();  // EXEC
    rst = 1'b1;
    #1;
    checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL rst_exec_pc_write got %b exp 0", PC_write); end
    tick();  // IDLE
    rst = 1'b0;
    #1;
    checks++; if (PC_write !== 1'b0 || fetch_req !== 1'b0 || instr_count !== 16'd0 || M1 !== 2'd1) begin errors++; $display("FAIL rst_exec_idle got pcw=%b freq=%b cnt=%0d M1=%0d exp 0/0/0/1", PC_write, fetch_req, instr_count, M1); end
    tick();
    checks++; if (fetch_req !== 1'b1 || PC_write !== 1'b0) begin errors++; $display("FAIL rst_exec_refetch got freq=%b pcw=%b exp 1/0", fetch_req, PC_write); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jumps();
    test_branches();
    test_stall();
    test_halt_op();
    test_timeout();
    test_valid_at_timeout();
    test_reset_in_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_update_sequencer.md
Name: pc_update_sequencer

Overview:
- Multi-cycle control FSM that sequences the program-counter write path.
- Drives the PC-source select M1: 0 = Jump_address, 1 = MUX_7_out, 2 = Reg_read_data_1. Drives the MUX_7 select M7: 0 = PC+1, 1 = branch target.
- Generates PC_write and IR_write, handles the instruction-fetch handshake, stalls and halt, and counts retired instructions.
- Sits in the control path between the decoder and the PC register / PC-source multiplexers.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- FETCH_TIMEOUT, 15, maximum FETCH wait cycles before fetch_err is raised; must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction memory has valid data while fetch_req=1.
- op_class  input  3  decoded class, sampled in DECODE: 0 seq, 1 jump, 2 jr, 3 beq, 4 bne, 5 halt; 6–7 are treated as seq.
- zero_flag  input  1  ALU zero result, sampled in EXEC.
- stall  input  1  hold request from the datapath.
- fetch_req  output  1  instruction fetch request.
- IR_write  output  1  load the instruction register.
- PC_write  output  1  PC register write enable.
- M1  output  2  PC-source select.
- M7  output  1  MUX_7 select.
- halted  output  1  core is halted.
- fetch_err  output  1  sticky fetch-timeout flag.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (any state, any cycle): next edge goes to IDLE. Outputs: fetch_req=0, IR_write=0, PC_write=0, M1=1, M7=0, halted=0, fetch_err=0, instr_count=0. A reset mid-instruction never produces PC_write.
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- IDLE: unconditionally go to FETCH on the next cycle.
- FETCH:
  - fetch_req=1.
  - When instr_valid=1: IR_write=1 for exactly that cycle, then go to DECODE.
  - A wait counter increments on each cycle with instr_valid=0.
  - When the counter reaches FETCH_TIMEOUT: set fetch_err (sticky until rst) and go to HALT.
- DECODE: latch op_class into an internal register; go to EXEC. op_class is ignored in every other state.
- EXEC:
  - Latched class halt: go to HALT with no PC_write.
  - Otherwise compute the registered selects:
    - seq: M1=1, M7=0.
    - jump: M1=0.
    - jr: M1=2.
    - beq: M1=1, M7=zero_flag.
    - bne: M1=1, M7=~zero_flag.
  - Go to UPDATE.
- UPDATE:
  - Normally: PC_write=1 for exactly one cycle, instr_count increments by 1 (wraps modulo 2^CNT_W), go to FETCH.
  - If stall=1: remain in UPDATE with PC_write=0 and M1/M7 held.
- M1/M7 are registered and stable from the EXEC→UPDATE edge until the next EXEC. The value 3 is never driven on M1.
- stall in states other than UPDATE: DECODE and EXEC also freeze while stall=1. FETCH ignores stall.
- HALT: halted=1; all enables 0; M1/M7 hold their last values; the FSM leaves HALT only on rst.
- Latency:
  - Minimum 4 cycles per instruction: FETCH with instr_valid already high, then DECODE, EXEC, UPDATE.
  - PC_write asserts 3 cycles after the IR_write cycle when there is no stall.
- Simultaneous instr_valid=1 and timeout in the same cycle: instr_valid wins, and fetch_err is not set.
- The wait counter clears on every FETCH entry.

Test Plan:
- rst=1 for 2 cycles then release, instr_valid=1 constantly, op_class=0 → IR_write pulses every 4 cycles, PC_write on the 4th cycle with M1=1, M7=0; instr_count = 1, 2, 3 after three instructions.
- op_class=1 then op_class=2 → first UPDATE has M1=0, second UPDATE has M1=2; PC_write is a single cycle each time.
- beq with zero_flag=1 → M7=1; beq with zero_flag=0 → M7=0; bne with zero_flag=0 → M7=1; M1=1 in all three cases.
- stall=1 for 3 cycles on entry to UPDATE → PC_write stays 0 for those 3 cycles, then asserts for 1 cycle; instr_count increments exactly once.
- instr_valid held 0 with FETCH_TIMEOUT=15 → fetch_err=1 and halted=1 after 15 wait cycles. Separately, op_class=5 → halted=1 with instr_count unchanged. In both cases rst clears everything back to the reset values.
- rst asserted while in EXEC of a jump → no PC_write occurs, state is IDLE after the edge, and instr_count=0.
